// File: rtl/seq_pkg.sv
// Shared constants and types for the sequence-capture block.
package seq_pkg;
  localparam int unsigned Q_W       = 3;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef logic [Q_W-1:0] q_t;

  // Legal successor of a sequence value (wraps modulo 2^Q_W).
  function automatic q_t q_succ(q_t q);
    return q + q_t'(1);
  endfunction
endpackage

// File: rtl/seq_capture_if.sv
// Upstream/consumer signal bundle for seq_capture; slave = DUT side, master = driver side.
interface seq_capture_if #(
  parameter int unsigned CNT_W = seq_pkg::CNT_W_DEF
);
  import seq_pkg::*;

  q_t               q_in;
  logic             count_in;
  logic             rd_en;
  q_t               rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] evt_cnt;
  logic             seq_err;

  modport slave (
    input  q_in, count_in, rd_en,
    output rd_data, rd_valid, empty, full, overflow, evt_cnt, seq_err
  );

  modport master (
    output q_in, count_in, rd_en,
    input  rd_data, rd_valid, empty, full, overflow, evt_cnt, seq_err
  );
endinterface

// File: rtl/seq_fifo.sv
// Capture FIFO: storage, wrapping pointers, occupancy and registered empty/full/overflow flags.
module seq_fifo
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  q_t   din,
  input  logic pop_req,
  output q_t   dout,
  output logic dout_valid,
  output logic empty,
  output logic full,
  output logic overflow
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  q_t            mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_next;
  logic          pop_ok;
  logic          push_ok;

  // A pop frees the slot in the same cycle, so a push into a full FIFO succeeds alongside it.
  assign pop_ok  = pop_req & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    occ_next = occ;
    case ({push_ok, pop_ok})
      2'b10:   occ_next = occ + CW'(1);
      2'b01:   occ_next = occ - CW'(1);
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      occ        <= occ_next;
      empty      <= (occ_next == '0);
      full       <= (occ_next == CW'(DEPTH));
      dout_valid <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      if (push & full & ~pop_ok) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/seq_capture.sv
// Captures q_in on each rising edge of count_in into a FIFO, counts events (saturating).
// Optional step checker on q_in is enabled by defining SEQ_STEP_CHECK_EN.
module seq_capture
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  seq_capture_if.slave bus
);
  logic             count_prev;
  logic             evt;
  logic [CNT_W-1:0] cnt;

  assign evt         = bus.count_in & ~count_prev;
  assign bus.evt_cnt = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      count_prev <= bus.count_in;
      if (evt && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

  seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (evt),
    .din        (bus.q_in),
    .pop_req    (bus.rd_en),
    .dout       (bus.rd_data),
    .dout_valid (bus.rd_valid),
    .empty      (bus.empty),
    .full       (bus.full),
    .overflow   (bus.overflow)
  );

`ifdef SEQ_STEP_CHECK_EN
  q_t   q_prev;
  logic q_prev_ok;
  logic err;

  // The first cycle after release only loads q_prev; comparisons start on the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_prev    <= '0;
      q_prev_ok <= 1'b0;
      err       <= 1'b0;
    end else begin
      q_prev    <= bus.q_in;
      q_prev_ok <= 1'b1;
      if (q_prev_ok && (bus.q_in != q_prev) && (bus.q_in != q_succ(q_prev))) err <= 1'b1;
    end
  end

  assign bus.seq_err = err;
`else
  assign bus.seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_seq_capture.sv
// Randomized scoreboard bench for seq_capture (CNT_W=8 and CNT_W=4 instances, DEPTH=4).
module tb_seq_capture;
  localparam int unsigned DEPTH = 4;
`ifdef SEQ_STEP_CHECK_EN
  localparam bit STEP_CHK = 1'b1;
`else
  localparam bit STEP_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_capture_if #(.CNT_W(8)) bus ();
  seq_capture_if #(.CNT_W(4)) bus4 ();

  assign bus4.q_in     = bus.q_in;
  assign bus4.count_in = bus.count_in;
  assign bus4.rd_en    = bus.rd_en;

  seq_capture #(.DEPTH(DEPTH), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  seq_capture #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int compared   = 0;
  int mismatched = 0;

  logic [2:0]  mdl [$];
  logic [2:0]  exp_q [$];
  int unsigned mdl_cnt;
  bit          mdl_ovf, mdl_prev, mdl_err, mdl_qv;
  logic [2:0]  mdl_qp;

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every rd_valid pulse must match the next expected pop.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", 1, 0);
      end else begin
        check("rd_data", int'(bus.rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_clear();
    mdl.delete();
    exp_q.delete();
    mdl_cnt = 0; mdl_ovf = 0; mdl_prev = 0; mdl_err = 0; mdl_qv = 0; mdl_qp = '0;
  endtask

  task automatic step(input bit cin, input logic [2:0] q, input bit rd);
    bus.count_in = cin;
    bus.q_in     = q;
    bus.rd_en    = rd;
    if (rd && mdl.size() > 0) exp_q.push_back(mdl.pop_front());
    if (cin && !mdl_prev) begin
      mdl_cnt++;
      if (mdl.size() < DEPTH) mdl.push_back(q);
      else mdl_ovf = 1;
    end
    mdl_prev = cin;
    if (STEP_CHK && mdl_qv && int'(q) != int'(mdl_qp) && int'(q) != (int'(mdl_qp) + 1) % 8)
      mdl_err = 1;
    mdl_qp = q;
    mdl_qv = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    #1;
    check({tag, ":sb_pending"}, exp_q.size(), 0);
    check({tag, ":empty"}, int'(bus.empty), int'(mdl.size() == 0));
    check({tag, ":full"}, int'(bus.full), int'(mdl.size() == DEPTH));
    check({tag, ":overflow"}, int'(bus.overflow), int'(mdl_ovf));
    check({tag, ":evt_cnt"}, int'(bus.evt_cnt), (mdl_cnt > 255) ? 255 : int'(mdl_cnt));
    check({tag, ":evt_cnt4"}, int'(bus4.evt_cnt), (mdl_cnt > 15) ? 15 : int'(mdl_cnt));
    check({tag, ":seq_err"}, int'(bus.seq_err), int'(mdl_err));
  endtask

  task automatic do_reset();
    #2;
    rst          = 1'b1;
    bus.count_in = 1'b0;
    bus.rd_en    = 1'b0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check_state("reset");
    check("reset:rd_valid", int'(bus.rd_valid), 0);
    check("reset:rd_data", int'(bus.rd_data), 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] cur;
    int unsigned r;
    bus.q_in = '0; bus.count_in = 1'b0; bus.rd_en = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // count_in high for four cycles: one event only
    repeat (4) step(1, 3'd5, 0);
    step(0, 3'd5, 0);
    check_state("hold_high");
    step(0, 3'd5, 1);
    check_state("hold_pop");
    step(0, 3'd5, 0);
    check("hold_pop:rd_valid_pulse", int'(bus.rd_valid), 0);

    // five events into a 4-deep FIFO, then drain
    for (int i = 1; i <= 5; i++) begin
      step(1, 3'(i), 0);
      step(0, 3'(i), 0);
    end
    check_state("overfill");
    check("overfill:full_const", int'(bus.full), 1);
    check("overfill:ovf_const", int'(bus.overflow), 1);
    repeat (4) step(0, 3'd5, 1);
    check_state("drain");
    step(0, 3'd5, 1);
    check("empty_rd:rd_valid", int'(bus.rd_valid), 0);
    check("empty_rd:rd_data_held", int'(bus.rd_data), 4);

    // reset with three entries stored
    step(1, 3'd6, 0); step(0, 3'd7, 0); step(1, 3'd0, 0);
    step(0, 3'd1, 0); step(1, 3'd2, 0);
    check_state("three_stored");
    do_reset();
    step(1, 3'd2, 0);
    check_state("post_reset_first_evt");

    // full FIFO with simultaneous event and pop
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      step(1, 3'(i), 0);
      step(0, 3'(i), 0);
    end
    step(1, 3'd6, 1);
    check_state("full_push_pop");
    repeat (4) step(0, 3'd6, 1);
    check_state("full_push_pop_drain");

    // empty FIFO with simultaneous event and pop
    step(1, 3'd6, 1);
    check("empty_push_pop:rd_valid", int'(bus.rd_valid), 0);
    check_state("empty_push_pop");
    step(0, 3'd6, 1);
    check_state("empty_push_pop_drain");

    // step checker: 3 -> 4 -> 4 -> 6
    do_reset();
    step(0, 3'd3, 0); step(0, 3'd4, 0); step(0, 3'd4, 0);
    check("step_hold:seq_err", int'(bus.seq_err), 0);
    step(0, 3'd6, 0);
    check("step_jump:seq_err", int'(bus.seq_err), int'(STEP_CHK));
    check_state("step_check");

    // 20 events saturate the 4-bit counter
    do_reset();
    repeat (20) begin
      step(1, 3'd1, 0);
      step(0, 3'd1, 0);
    end
    check_state("saturate");
    check("saturate:evt_cnt4_const", int'(bus4.evt_cnt), 15);

    // randomized traffic
    do_reset();
    cur = '0;
    repeat (400) begin
      r = $urandom_range(0, 19);
      if (r < 12) cur = cur;
      else if (r < 19) cur = cur + 3'd1;
      else cur = 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), cur, 1'($urandom_range(0, 2) == 0));
      check_state("random");
    end
    repeat (DEPTH + 1) step(0, cur, 1);
    check_state("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/seq_capture.md
SEQ_CAPTURE -- requirements
Module: seq_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of the event counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port q_in  input  3  sequence value from the upstream sequence counter.
REQ-006 SHALL have port count_in  input  1  sequence-detect flag from the upstream sequence counter.
REQ-007 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-008 SHALL have port rd_data  output  3  popped q value, registered.
REQ-009 SHALL have port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-010 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port overflow  output  1  sticky, event dropped while full.
REQ-013 SHALL have port evt_cnt  output  CNT_W  total detected events, saturating.
REQ-014 SHALL have port seq_err  output  1  sticky, illegal q_in step (see Configuration).

Function
REQ-015 SHALL register count_in each cycle; an event is count_in=1 while the previous sample is 0 (rising edge only).
REQ-016 SHALL push the same-cycle q_in value into the FIFO on each event when not full.
REQ-017 SHALL drop the event on a full FIFO with no simultaneous pop, and set overflow to 1 on the next edge.
REQ-018 SHALL, with rd_en=1 and not empty, pop the head, drive it on rd_data and pulse rd_valid=1 on the next edge.
REQ-019 SHALL ignore rd_en on an empty FIFO: rd_valid=0, rd_data held.
REQ-020 SHALL accept a simultaneous push and pop when full: both succeed, occupancy unchanged, overflow not set.
REQ-021 SHALL handle a simultaneous push and pop when empty as push only: occupancy becomes 1, rd_valid=0.
REQ-022 SHALL wrap read and write pointers modulo DEPTH and keep an occupancy counter of width log2(DEPTH)+1.
REQ-023 SHALL drive empty and full as registered decodes of the occupancy counter, correct in the cycle after each update.
REQ-024 SHALL increment evt_cnt on every event, including dropped events, and saturate at 2^CNT_W-1 with no wrap.
REQ-025 SHALL keep overflow and seq_err set until reset.

Reset
REQ-026 SHALL, on rst=1 regardless of clk, clear the pointers, occupancy, rd_data=0, rd_valid=0, overflow=0, seq_err=0, evt_cnt=0 and the count_in history=0; this gives empty=1 and full=0.
REQ-027 SHALL discard FIFO contents on reset mid-operation; the first event after release is a count_in rising edge seen from history 0.

Configuration
REQ-028 SHALL provide the macro SEQ_STEP_CHECK_EN.
REQ-029 SHALL, with SEQ_STEP_CHECK_EN defined, compare q_in to its previous-cycle value from the second cycle after reset release; any change other than +1 mod 8 sets seq_err; hold is legal.
REQ-030 SHALL, with SEQ_STEP_CHECK_EN undefined, tie seq_err to 0 and omit the previous-q register.

Structure
REQ-031 SHALL take Q_W=3 and the default DEPTH and CNT_W constants from shared package seq_pkg.
REQ-032 SHALL implement the FIFO storage, pointers and flags in sub-module seq_fifo; edge detect, counter and checker stay in seq_capture.

Verification
REQ-033 SHALL cover: reset asserted mid-stream with 3 entries stored -> next cycle empty=1, evt_cnt=0, overflow=0.
REQ-034 SHALL cover: count_in held high 4 cycles with q_in=5 -> exactly one push, evt_cnt=1; pop -> rd_data=5, rd_valid=1 for one cycle.
REQ-035 SHALL cover: 5 events with q_in=1,2,3,4,5, DEPTH=4, no reads -> full=1, overflow=1, evt_cnt=5; pops return 1,2,3,4, then empty=1.
REQ-036 SHALL cover: full FIFO plus simultaneous event (q_in=6) and rd_en -> overflow=0, occupancy 4, tail entry 6.
REQ-037 SHALL cover: CNT_W=4 with 20 events -> evt_cnt=15.
REQ-038 SHALL cover: with SEQ_STEP_CHECK_EN, q_in 3->4->4->6 -> seq_err=1 after the 4->6 step; without the macro, seq_err=0.
